// File: rtl/accelerator_tensor_stream_sequencer.sv
// Multi-channel synthetic tensor stimulus sequencer: streams SIZE_I x SIZE_J elements per
// enabled channel with I_ENABLE/J_ENABLE strobes, then kicks the accelerator and waits for READY.
module accelerator_tensor_stream_sequencer #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int CHANNELS     = 4,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [1:0]              MODE,
  input  logic [DATA_SIZE-1:0]    SEED,
  input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
  input  logic [CHANNELS-1:0]     CHANNEL_MASK,
  input  logic [CONTROL_SIZE-1:0] TIMEOUT_CYCLES,
  input  logic                    STALL,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic [CH_W-1:0]         CHANNEL_OUT,
  output logic                    I_ENABLE,
  output logic                    J_ENABLE,
  output logic                    ACC_START,
  input  logic                    ACC_READY,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    TIMEOUT_ERROR,
  output logic [DATA_SIZE-1:0]    ELEMENT_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STREAM, S_KICK, S_WAIT, S_FINISH
  } state_t;

  localparam logic [DATA_SIZE-1:0]    D_ONE = 1;
  localparam logic [CONTROL_SIZE-1:0] C_ONE = 1;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [DATA_SIZE-1:0]    seed_q, seed_d;
  logic [DATA_SIZE-1:0]    size_i_q, size_i_d;
  logic [DATA_SIZE-1:0]    size_j_q, size_j_d;
  logic [CHANNELS-1:0]     mask_q, mask_d;
  logic [CONTROL_SIZE-1:0] tmo_q, tmo_d;
  logic [CONTROL_SIZE-1:0] wait_q, wait_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [DATA_SIZE-1:0]    i_q, i_d;
  logic [DATA_SIZE-1:0]    j_q, j_d;
  logic [DATA_SIZE-1:0]    pat_q, pat_d;
  logic [DATA_SIZE-1:0]    data_q, data_d;
  logic [CH_W-1:0]         chout_q, chout_d;
  logic                    ien_q, ien_d;
  logic                    jen_q, jen_d;
  logic                    acc_start_q, acc_start_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_SIZE-1:0]    count_q, count_d;
  logic [CH_W:0]           fc;

  function automatic logic [DATA_SIZE-1:0] pattern_init(input logic [1:0] mode,
                                                        input logic [DATA_SIZE-1:0] seed);
    if (mode == 2'b10 && seed == '0) return D_ONE;
    return seed;
  endfunction

  function automatic logic [DATA_SIZE-1:0] pattern_next(input logic [1:0] mode,
                                                        input logic [DATA_SIZE-1:0] d);
    case (mode)
      2'b01:   return d;
      2'b10:   return {d[DATA_SIZE-2:0], d[DATA_SIZE-1] ^ d[DATA_SIZE-2]};
      default: return d + D_ONE;
    endcase
  endfunction

  // Returns {found, index} of the lowest set mask bit at or above 'first'.
  function automatic logic [CH_W:0] find_ch(input logic [CHANNELS-1:0] m, input int first);
    logic [CH_W:0] r;
    r = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (c >= first && m[c]) r = {1'b1, c[CH_W-1:0]};
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    size_i_d    = size_i_q;
    size_j_d    = size_j_q;
    mask_d      = mask_q;
    tmo_d       = tmo_q;
    wait_d      = wait_q;
    ch_d        = ch_q;
    i_d         = i_q;
    j_d         = j_q;
    pat_d       = pat_q;
    data_d      = data_q;
    chout_d     = chout_q;
    ien_d       = 1'b0;
    jen_d       = 1'b0;
    acc_start_d = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    count_d     = count_q;
    fc          = '0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          mode_d   = MODE;
          seed_d   = SEED;
          size_i_d = SIZE_I_IN;
          size_j_d = SIZE_J_IN;
          mask_d   = CHANNEL_MASK;
          tmo_d    = TIMEOUT_CYCLES;
          count_d  = '0;
          err_d    = 1'b0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        fc     = find_ch(mask_q, 0);
        ch_d   = fc[CH_W-1:0];
        i_d    = '0;
        j_d    = '0;
        wait_d = '0;
        pat_d  = pattern_init(mode_q, seed_q);
        if (fc[CH_W] && size_i_q != '0 && size_j_q != '0) state_d = S_STREAM;
        else                                              state_d = S_FINISH;
      end
      S_STREAM: begin
        if (!STALL) begin
          jen_d   = 1'b1;
          ien_d   = (j_q == '0);
          data_d  = pat_q;
          chout_d = ch_q;
          count_d = count_q + D_ONE;
          pat_d   = pattern_next(mode_q, pat_q);
          if (j_q == size_j_q - D_ONE) begin
            j_d = '0;
            if (i_q == size_i_q - D_ONE) begin
              // Channel finished: hop straight to the next enabled channel with no bubble.
              i_d   = '0;
              pat_d = pattern_init(mode_q, seed_q);
              fc    = find_ch(mask_q, int'(ch_q) + 1);
              if (fc[CH_W]) ch_d = fc[CH_W-1:0];
              else          state_d = S_KICK;
            end else begin
              i_d = i_q + D_ONE;
            end
          end else begin
            j_d = j_q + D_ONE;
          end
        end
      end
      S_KICK: begin
        acc_start_d = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // READY takes priority over a timeout expiring in the same cycle.
        if (ACC_READY) begin
          state_d = S_FINISH;
        end else if (tmo_q != '0 && wait_q + C_ONE == tmo_q) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          wait_d = wait_q + C_ONE;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      chout_q     <= '0;
      ien_q       <= 1'b0;
      jen_q       <= 1'b0;
      acc_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      chout_q     <= chout_d;
      ien_q       <= ien_d;
      jen_q       <= jen_d;
      acc_start_q <= acc_start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  // Run configuration and walk counters are always (re)loaded before use.
  always_ff @(posedge CLK) begin
    mode_q   <= mode_d;
    seed_q   <= seed_d;
    size_i_q <= size_i_d;
    size_j_q <= size_j_d;
    mask_q   <= mask_d;
    tmo_q    <= tmo_d;
    wait_q   <= wait_d;
    ch_q     <= ch_d;
    i_q      <= i_d;
    j_q      <= j_d;
    pat_q    <= pat_d;
  end

  assign DATA_OUT      = data_q;
  assign CHANNEL_OUT   = chout_q;
  assign I_ENABLE      = ien_q;
  assign J_ENABLE      = jen_q;
  assign ACC_START     = acc_start_q;
  assign BUSY          = (state_q != S_IDLE);
  assign DONE          = done_q;
  assign TIMEOUT_ERROR = err_q;
  assign ELEMENT_COUNT = count_q;

endmodule

// File: tb/tb_accelerator_tensor_stream_sequencer.sv
// Scoreboard bench for accelerator_tensor_stream_sequencer (8-bit data, 4 channels).
module tb_accelerator_tensor_stream_sequencer;
  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           START = 1'b0;
  logic [1:0]     MODE = '0;
  logic [DW-1:0]  SEED = '0;
  logic [DW-1:0]  SIZE_I_IN = '0;
  logic [DW-1:0]  SIZE_J_IN = '0;
  logic [NCH-1:0] CHANNEL_MASK = '0;
  logic [CW-1:0]  TIMEOUT_CYCLES = '0;
  logic           STALL = 1'b0;
  logic           ACC_READY = 1'b0;
  logic [DW-1:0]  DATA_OUT;
  logic [CHW-1:0] CHANNEL_OUT;
  logic           I_ENABLE, J_ENABLE, ACC_START, BUSY, DONE, TIMEOUT_ERROR;
  logic [DW-1:0]  ELEMENT_COUNT;

  accelerator_tensor_stream_sequencer #(.DATA_SIZE(DW), .CONTROL_SIZE(CW), .CHANNELS(NCH)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .SEED(SEED),
    .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN), .CHANNEL_MASK(CHANNEL_MASK),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .STALL(STALL), .DATA_OUT(DATA_OUT),
    .CHANNEL_OUT(CHANNEL_OUT), .I_ENABLE(I_ENABLE), .J_ENABLE(J_ENABLE),
    .ACC_START(ACC_START), .ACC_READY(ACC_READY), .BUSY(BUSY), .DONE(DONE),
    .TIMEOUT_ERROR(TIMEOUT_ERROR), .ELEMENT_COUNT(ELEMENT_COUNT)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0]  exp_data_q[$];
  logic [CHW-1:0] exp_ch_q[$];
  logic           exp_ien_q[$];

  int first_j, last_j, n_j, acc_cnt, acc_cyc, done_cnt, done_cyc, stall_cycles, stall_bad;

  task automatic build_expected(input logic [1:0] mode, input logic [DW-1:0] seed,
                                input int si, input int sj, input logic [NCH-1:0] mask);
    logic [DW-1:0] d;
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        d = (mode == 2'd2 && seed == '0) ? DW'(1) : seed;
        for (int idx = 0; idx < si * sj; idx++) begin
          if (mode == 2'd1)      exp_data_q.push_back(seed);
          else if (mode == 2'd2) exp_data_q.push_back(d);
          else                   exp_data_q.push_back(seed + DW'(idx));
          exp_ch_q.push_back(CHW'(c));
          exp_ien_q.push_back((idx % sj) == 0);
          d = {d[DW-2:0], d[DW-1] ^ d[DW-2]};
        end
      end
    end
  endtask

  task automatic start_run(input logic [1:0] mode, input logic [DW-1:0] seed, input int si,
                           input int sj, input logic [NCH-1:0] mask, input int tmo);
    @(negedge CLK);
    MODE = mode; SEED = seed; SIZE_I_IN = DW'(si); SIZE_J_IN = DW'(sj);
    CHANNEL_MASK = mask; TIMEOUT_CYCLES = CW'(tmo); START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Runs until DONE (bounded), drives READY/STALL and pops the scoreboard on every J_ENABLE.
  task automatic collect(input int ready_delay, input int stall_after, input int stall_len,
                         input int max_cyc);
    int ready_at, stall_left;
    logic in_stall;
    logic [DW-1:0] stall_val, ed;
    logic [CHW-1:0] ec;
    logic ei;
    first_j = -1; last_j = -1; n_j = 0; acc_cnt = 0; acc_cyc = -1; done_cnt = 0;
    done_cyc = -1; stall_cycles = 0; stall_bad = 0;
    ready_at = -1; stall_left = 0; in_stall = 1'b0; stall_val = '0;
    for (int cyc = 1; cyc <= max_cyc && done_cyc < 0; cyc++) begin
      @(negedge CLK);
      START = 1'b0;
      if (in_stall) begin
        stall_cycles++;
        if (J_ENABLE || I_ENABLE || DATA_OUT != stall_val) stall_bad++;
      end
      if (J_ENABLE) begin
        n_j++;
        if (first_j < 0) first_j = cyc;
        last_j = cyc;
        vectors++;
        if (exp_data_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_extra: got data %0h ch %0d, required no element", DATA_OUT, CHANNEL_OUT);
        end else begin
          ed = exp_data_q.pop_front(); ec = exp_ch_q.pop_front(); ei = exp_ien_q.pop_front();
          if ({DATA_OUT, CHANNEL_OUT, I_ENABLE} !== {ed, ec, ei}) begin
            miscompares++;
            $display("FAIL scoreboard_element: got data %0h ch %0d ien %0b, required data %0h ch %0d ien %0b",
                     DATA_OUT, CHANNEL_OUT, I_ENABLE, ed, ec, ei);
          end
        end
      end
      if (ACC_START) begin
        acc_cnt++; acc_cyc = cyc;
        if (ready_delay >= 0) ready_at = cyc + ready_delay;
      end
      if (DONE) begin done_cnt++; done_cyc = cyc; end
      ACC_READY = (cyc == ready_at);
      if (stall_after > 0 && J_ENABLE && n_j == stall_after) begin
        stall_left = stall_len; stall_val = DATA_OUT;
      end
      in_stall = (stall_left > 0);
      STALL = in_stall;
      if (stall_left > 0) stall_left--;
    end
    ACC_READY = 1'b0; STALL = 1'b0;
    vectors++;
    if (exp_data_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_missing: got %0d elements left unseen, required 0", exp_data_q.size());
    end
    vectors++;
    if (done_cyc < 0) begin
      miscompares++;
      $display("FAIL done_bound: got no DONE within %0d cycles, required DONE", max_cyc);
    end
    exp_data_q.delete(); exp_ch_q.delete(); exp_ien_q.delete();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({DATA_OUT, CHANNEL_OUT, I_ENABLE, J_ENABLE, ACC_START, BUSY, DONE, TIMEOUT_ERROR, ELEMENT_COUNT} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data %0h ch %0d i %0b j %0b acc %0b busy %0b done %0b err %0b cnt %0h, required all 0",
               DATA_OUT, CHANNEL_OUT, I_ENABLE, J_ENABLE, ACC_START, BUSY, DONE, TIMEOUT_ERROR, ELEMENT_COUNT);
    end
    RST = 1'b1;
    @(negedge CLK);
    vectors++;
    if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %0b required 0", BUSY); end
  endtask

  task automatic test_basic();
    build_expected(2'd0, 8'd10, 2, 3, 4'b0001);
    start_run(2'd0, 8'd10, 2, 3, 4'b0001, 0);
    collect(5, 0, 0, 100);
    vectors++;
    if (first_j !== 2) begin miscompares++; $display("FAIL basic_latency: got %0d required 2", first_j); end
    vectors++;
    if (n_j !== 6 || last_j - first_j !== 5) begin
      miscompares++; $display("FAIL basic_contiguous: got %0d elements span %0d, required 6 span 5", n_j, last_j - first_j);
    end
    vectors++;
    if (acc_cnt !== 1 || acc_cyc !== 8) begin
      miscompares++; $display("FAIL basic_acc_start: got %0d pulses at %0d, required 1 at 8", acc_cnt, acc_cyc);
    end
    vectors++;
    if (done_cyc - acc_cyc !== 7) begin
      miscompares++; $display("FAIL basic_done_time: got %0d required 7", done_cyc - acc_cyc);
    end
    vectors++;
    if (ELEMENT_COUNT !== 8'd6 || TIMEOUT_ERROR !== 1'b0 || BUSY !== 1'b0) begin
      miscompares++; $display("FAIL basic_final: got cnt %0d err %0b busy %0b, required 6 0 0", ELEMENT_COUNT, TIMEOUT_ERROR, BUSY);
    end
    @(negedge CLK);
    vectors++;
    if (DONE !== 1'b0 || ELEMENT_COUNT !== 8'd6) begin
      miscompares++; $display("FAIL basic_done_pulse: got done %0b cnt %0d, required 0 6", DONE, ELEMENT_COUNT);
    end
  endtask

  task automatic test_multichannel();
    build_expected(2'd1, 8'd7, 1, 2, 4'b1010);
    start_run(2'd1, 8'd7, 1, 2, 4'b1010, 0);
    collect(2, 0, 0, 100);
    vectors++;
    if (n_j !== 4 || last_j - first_j !== 3) begin
      miscompares++; $display("FAIL multi_no_gap: got %0d elements span %0d, required 4 span 3", n_j, last_j - first_j);
    end
    vectors++;
    if (ELEMENT_COUNT !== 8'd4) begin miscompares++; $display("FAIL multi_count: got %0d required 4", ELEMENT_COUNT); end
  endtask

  task automatic test_backpressure();
    build_expected(2'd0, 8'd10, 2, 3, 4'b0001);
    start_run(2'd0, 8'd10, 2, 3, 4'b0001, 0);
    collect(5, 2, 3, 100);
    vectors++;
    if (stall_cycles !== 3 || stall_bad !== 0) begin
      miscompares++; $display("FAIL stall_hold: got %0d stalled cycles %0d bad, required 3 and 0", stall_cycles, stall_bad);
    end
    vectors++;
    if (n_j !== 6 || last_j - first_j !== 8) begin
      miscompares++; $display("FAIL stall_resume: got %0d elements span %0d, required 6 span 8", n_j, last_j - first_j);
    end
    vectors++;
    if (ELEMENT_COUNT !== 8'd6) begin miscompares++; $display("FAIL stall_count: got %0d required 6", ELEMENT_COUNT); end
  endtask

  task automatic test_timeout();
    build_expected(2'd0, 8'd10, 2, 3, 4'b0001);
    start_run(2'd0, 8'd10, 2, 3, 4'b0001, 4);
    collect(-1, 0, 0, 100);
    vectors++;
    if (TIMEOUT_ERROR !== 1'b1 || done_cyc - acc_cyc !== 5) begin
      miscompares++; $display("FAIL timeout_fire: got err %0b done after %0d, required 1 after 5", TIMEOUT_ERROR, done_cyc - acc_cyc);
    end
    build_expected(2'd0, 8'd10, 2, 3, 4'b0001);
    start_run(2'd0, 8'd10, 2, 3, 4'b0001, 4);
    collect(3, 0, 0, 100);
    vectors++;
    if (TIMEOUT_ERROR !== 1'b0 || done_cyc - acc_cyc !== 5) begin
      miscompares++; $display("FAIL timeout_ready_wins: got err %0b done after %0d, required 0 after 5", TIMEOUT_ERROR, done_cyc - acc_cyc);
    end
  endtask

  task automatic test_degenerate();
    start_run(2'd0, 8'd1, 2, 3, 4'b0000, 0);
    collect(1, 0, 0, 50);
    vectors++;
    if (done_cyc !== 2 || acc_cnt !== 0 || n_j !== 0 || ELEMENT_COUNT !== 8'd0) begin
      miscompares++; $display("FAIL degen_mask: got done %0d acc %0d elems %0d cnt %0d, required 2 0 0 0",
                              done_cyc, acc_cnt, n_j, ELEMENT_COUNT);
    end
    start_run(2'd0, 8'd1, 2, 0, 4'b0001, 0);
    collect(1, 0, 0, 50);
    vectors++;
    if (done_cyc !== 2 || acc_cnt !== 0 || n_j !== 0 || ELEMENT_COUNT !== 8'd0) begin
      miscompares++; $display("FAIL degen_size: got done %0d acc %0d elems %0d cnt %0d, required 2 0 0 0",
                              done_cyc, acc_cnt, n_j, ELEMENT_COUNT);
    end
  endtask

  task automatic test_start_while_busy();
    build_expected(2'd0, 8'd20, 1, 4, 4'b0001);
    start_run(2'd0, 8'd20, 1, 4, 4'b0001, 0);
    @(negedge CLK);
    START = 1'b1; SEED = 8'd99; MODE = 2'd1; CHANNEL_MASK = 4'b1111; SIZE_J_IN = 8'd2;
    collect(2, 0, 0, 100);
    vectors++;
    if (n_j !== 4 || ELEMENT_COUNT !== 8'd4) begin
      miscompares++; $display("FAIL busy_latched: got %0d elems cnt %0d, required 4 4", n_j, ELEMENT_COUNT);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      vectors++;
      if (BUSY !== 1'b0) begin miscompares++; $display("FAIL busy_no_queue: got busy %0b required 0", BUSY); end
    end
  endtask

  task automatic test_lfsr();
    build_expected(2'd2, 8'd0, 1, 3, 4'b0001);
    start_run(2'd2, 8'd0, 1, 3, 4'b0001, 0);
    collect(1, 0, 0, 100);
    vectors++;
    if (n_j !== 3) begin miscompares++; $display("FAIL lfsr_len: got %0d required 3", n_j); end
  endtask

  task automatic test_reset_midrun();
    int seen_done;
    start_run(2'd0, 8'h50, 4, 4, 4'b0001, 0);
    repeat (4) @(negedge CLK);
    vectors++;
    if (J_ENABLE !== 1'b1) begin miscompares++; $display("FAIL midrun_streaming: got j %0b required 1", J_ENABLE); end
    RST = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({DATA_OUT, CHANNEL_OUT, I_ENABLE, J_ENABLE, ACC_START, BUSY, DONE, TIMEOUT_ERROR, ELEMENT_COUNT} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: got data %0h j %0b busy %0b done %0b cnt %0h, required all 0",
               DATA_OUT, J_ENABLE, BUSY, DONE, ELEMENT_COUNT);
    end
    RST = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (DONE || BUSY) seen_done++;
    end
    vectors++;
    if (seen_done !== 0) begin miscompares++; $display("FAIL midrun_no_done: got %0d active cycles required 0", seen_done); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_multichannel();
    test_backpressure();
    test_timeout();
    test_degenerate();
    test_start_while_busy();
    test_lfsr();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
